// File: rtl/voice_allocator_if.sv
// Event handshake and voice-bank signals shared by the voice allocator and its neighbours.
// The slave side is the allocator; the master side is the event framer / voice bank.
interface voice_allocator_if #(
   parameter int NUM_VOICES = 8
);
   logic                    event_valid;
   logic [7:0]              event_command;
   logic [6:0]              event_param1;
   logic [6:0]              event_param2;
   logic                    event_ack;
   logic [NUM_VOICES-1:0]   voice_idle;
   logic [NUM_VOICES-1:0]   voice_gate;
   logic [7*NUM_VOICES-1:0] voice_note;
   logic                    busy;

   modport slave (
      input  event_valid, event_command, event_param1, event_param2, voice_idle,
      output event_ack, voice_gate, voice_note, busy
   );

   modport master (
      output event_valid, event_command, event_param1, event_param2, voice_idle,
      input  event_ack, voice_gate, voice_note, busy
   );
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: assigns note-on events to free voices, steals the
// least-recently-assigned voice when all are busy, and releases voices on note-off.
module voice_allocator #(
   parameter int NUM_VOICES = 8,
   parameter int STEAL_GAP  = 64
) (
   input logic          clk,
   input logic          rst,
   voice_allocator_if.slave vif
);

   localparam int IW = $clog2(NUM_VOICES);
   localparam int CW = $clog2(STEAL_GAP + 1);

   typedef enum logic [2:0] {
      IDLE,
      DECODE,
      SCAN,
      APPLY,
      STEAL_WAIT
   } state_t;

   state_t                state_q, state_d;
   logic [3:0]            cmdHi_q, cmdHi_d;
   logic [6:0]            param1_q, param1_d;
   logic [6:0]            param2_q, param2_d;
   logic                  ack_q, ack_d;
   logic                  noteOff_q, noteOff_d;
   logic [NUM_VOICES-1:0] gate_q, gate_d;
   logic [6:0]            note_q [NUM_VOICES];
   logic [6:0]            note_d [NUM_VOICES];
   logic [IW-1:0]         age_q [NUM_VOICES];
   logic [IW-1:0]         age_d [NUM_VOICES];
   logic [IW-1:0]         scanIdx_q, scanIdx_d;
   logic                  matchFound_q, matchFound_d;
   logic [IW-1:0]         matchIdx_q, matchIdx_d;
   logic                  freeFound_q, freeFound_d;
   logic [IW-1:0]         freeIdx_q, freeIdx_d;
   logic [IW-1:0]         oldestIdx_q, oldestIdx_d;
   logic [IW-1:0]         stealIdx_q, stealIdx_d;
   logic [CW-1:0]         stealCnt_q, stealCnt_d;
   logic [IW-1:0]         applyTarget;

   assign applyTarget = matchFound_q ? matchIdx_q : (freeFound_q ? freeIdx_q : oldestIdx_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cmdHi_q      <= '0;
         param1_q     <= '0;
         param2_q     <= '0;
         ack_q        <= 1'b0;
         noteOff_q    <= 1'b0;
         gate_q       <= '0;
         scanIdx_q    <= '0;
         matchFound_q <= 1'b0;
         matchIdx_q   <= '0;
         freeFound_q  <= 1'b0;
         freeIdx_q    <= '0;
         oldestIdx_q  <= '0;
         stealIdx_q   <= '0;
         stealCnt_q   <= '0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            note_q[i] <= '0;
            age_q[i]  <= IW'(i);
         end
      end else begin
         state_q      <= state_d;
         cmdHi_q      <= cmdHi_d;
         param1_q     <= param1_d;
         param2_q     <= param2_d;
         ack_q        <= ack_d;
         noteOff_q    <= noteOff_d;
         gate_q       <= gate_d;
         scanIdx_q    <= scanIdx_d;
         matchFound_q <= matchFound_d;
         matchIdx_q   <= matchIdx_d;
         freeFound_q  <= freeFound_d;
         freeIdx_q    <= freeIdx_d;
         oldestIdx_q  <= oldestIdx_d;
         stealIdx_q   <= stealIdx_d;
         stealCnt_q   <= stealCnt_d;
         note_q       <= note_d;
         age_q        <= age_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cmdHi_d      = cmdHi_q;
      param1_d     = param1_q;
      param2_d     = param2_q;
      ack_d        = 1'b0;
      noteOff_d    = noteOff_q;
      gate_d       = gate_q;
      scanIdx_d    = scanIdx_q;
      matchFound_d = matchFound_q;
      matchIdx_d   = matchIdx_q;
      freeFound_d  = freeFound_q;
      freeIdx_d    = freeIdx_q;
      oldestIdx_d  = oldestIdx_q;
      stealIdx_d   = stealIdx_q;
      stealCnt_d   = stealCnt_q;
      note_d       = note_q;
      age_d        = age_q;

      case (state_q)
         IDLE: begin
            if (vif.event_valid) begin
               cmdHi_d  = vif.event_command[7:4];
               param1_d = vif.event_param1;
               param2_d = vif.event_param2;
               ack_d    = 1'b1;
               state_d  = DECODE;
            end
         end

         DECODE: begin
            scanIdx_d    = '0;
            matchFound_d = 1'b0;
            freeFound_d  = 1'b0;
            state_d      = IDLE;
            if (cmdHi_q == 4'h9 && param2_q != 7'd0) begin
               noteOff_d = 1'b0;
               state_d   = SCAN;
            end else if (cmdHi_q == 4'h8 || cmdHi_q == 4'h9) begin
               noteOff_d = 1'b1;
               state_d   = SCAN;
            end else if (cmdHi_q == 4'hB && param1_q == 7'd123) begin
               gate_d = '0;
            end
         end

         // One voice per cycle; note-off releases matching voices as they are visited.
         SCAN: begin
            if (gate_q[scanIdx_q] && note_q[scanIdx_q] == param1_q) begin
               if (noteOff_q) begin
                  gate_d[scanIdx_q] = 1'b0;
               end
               if (!matchFound_q) begin
                  matchFound_d = 1'b1;
                  matchIdx_d   = scanIdx_q;
               end
            end
            if (vif.voice_idle[scanIdx_q] && !gate_q[scanIdx_q] && !freeFound_q) begin
               freeFound_d = 1'b1;
               freeIdx_d   = scanIdx_q;
            end
            if (age_q[scanIdx_q] == IW'(NUM_VOICES - 1)) begin
               oldestIdx_d = scanIdx_q;
            end
            if (scanIdx_q == IW'(NUM_VOICES - 1)) begin
               state_d = noteOff_q ? IDLE : APPLY;
            end else begin
               scanIdx_d = scanIdx_q + IW'(1);
            end
         end

         // Target becomes youngest; everything younger than it ages by one.
         APPLY: begin
            for (int j = 0; j < NUM_VOICES; j++) begin
               if (age_q[j] < age_q[applyTarget]) begin
                  age_d[j] = age_q[j] + IW'(1);
               end
            end
            age_d[applyTarget] = '0;
            state_d            = IDLE;
            if (!matchFound_q) begin
               note_d[applyTarget] = param1_q;
               if (freeFound_q) begin
                  gate_d[applyTarget] = 1'b1;
               end else begin
                  gate_d[applyTarget] = 1'b0;
                  stealIdx_d          = applyTarget;
                  stealCnt_d          = '0;
                  state_d             = STEAL_WAIT;
               end
            end
         end

         STEAL_WAIT: begin
            if (stealCnt_q == CW'(STEAL_GAP - 1)) begin
               gate_d[stealIdx_q] = 1'b1;
               state_d            = IDLE;
            end else begin
               stealCnt_d = stealCnt_q + CW'(1);
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign vif.event_ack  = ack_q;
   assign vif.voice_gate = gate_q;
   assign vif.busy       = (state_q != IDLE);

   for (genvar g = 0; g < NUM_VOICES; g++) begin : g_note
      assign vif.voice_note[7*g +: 7] = note_q[g];
   end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed table, timing corner cases,
// and randomized events checked against an LRU-list reference model.
module tb_voice_allocator;

   localparam int NV  = 8;
   localparam int GAP = 64;

   typedef struct {
      logic [7:0] cmd;
      logic [6:0] p1;
      logic [6:0] p2;
      logic [7:0] expGate;
      int         voice;
      logic [6:0] expNote;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   vecCount  = 0;
   int   missCount = 0;

   voice_allocator_if #(.NUM_VOICES(NV)) vif ();

   voice_allocator #(.NUM_VOICES(NV), .STEAL_GAP(GAP)) dut (
      .clk (clk),
      .rst (rst),
      .vif (vif)
   );

   always #5 clk = ~clk;

   // Reference model: gates, notes and a recency list (front = most recently assigned)
   bit         mGate [NV];
   logic [6:0] mNote [NV];
   int         lru [$];

   task automatic modelReset();
      lru.delete();
      for (int i = 0; i < NV; i++) begin
         mGate[i] = 0;
         mNote[i] = '0;
         lru.push_back(i);
      end
   endtask

   task automatic modelEvent(input logic [7:0] cmd, input logic [6:0] p1,
                             input logic [6:0] p2, input logic [NV-1:0] idle);
      int t;
      logic [3:0] hi;
      hi = cmd[7:4];
      if (hi == 4'h9 && p2 != 0) begin
         t = -1;
         for (int i = 0; i < NV; i++)
            if (t < 0 && mGate[i] && mNote[i] == p1) t = i;
         for (int i = 0; i < NV; i++)
            if (t < 0 && idle[i] && !mGate[i]) t = i;
         if (t < 0) t = lru[lru.size()-1];
         mNote[t] = p1;
         mGate[t] = 1;
         for (int k = 0; k < lru.size(); k++)
            if (lru[k] == t) begin
               lru.delete(k);
               break;
            end
         lru.push_front(t);
      end else if (hi == 4'h8 || hi == 4'h9) begin
         for (int i = 0; i < NV; i++)
            if (mGate[i] && mNote[i] == p1) mGate[i] = 0;
      end else if (hi == 4'hB && p1 == 7'd123) begin
         for (int i = 0; i < NV; i++) mGate[i] = 0;
      end
   endtask

   function automatic logic [6:0] noteOf(input int i);
      return vif.voice_note[7*i +: 7];
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      vecCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      vif.event_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Returns at the negedge of the cycle in which event_ack is high.
   task automatic applyStimulus(input logic [7:0] cmd, input logic [6:0] p1, input logic [6:0] p2);
      int n = 0;
      @(negedge clk);
      vif.event_command = cmd;
      vif.event_param1  = p1;
      vif.event_param2  = p2;
      vif.event_valid   = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!vif.event_ack && n < 300);
      vif.event_valid = 1'b0;
      if (!vif.event_ack) begin
         vecCount++;
         missCount++;
         $display("[TB] FAIL ack_timeout: got 0 expected 1");
      end
   endtask

   task automatic waitIdle();
      int n = 0;
      while (vif.busy && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (vif.busy) begin
         vecCount++;
         missCount++;
         $display("[TB] FAIL busy_timeout: got 1 expected 0");
      end
   endtask

   vec_t vecs [9];

   initial begin
      int low;
      logic [7:0]    rc;
      logic [6:0]    rp1, rp2;
      logic [NV-1:0] ridle;
      logic [63:0]   expGate, expNotes;
      int r;

      vecs[0] = '{8'h90, 7'd64, 7'd100, 8'h03, 1, 7'd64};
      vecs[1] = '{8'h90, 7'd67, 7'd100, 8'h07, 2, 7'd67};
      vecs[2] = '{8'h90, 7'd64, 7'd90,  8'h07, 1, 7'd64};
      vecs[3] = '{8'h80, 7'd64, 7'd0,   8'h05, 1, 7'd64};
      vecs[4] = '{8'h90, 7'd67, 7'd0,   8'h01, 2, 7'd67};
      vecs[5] = '{8'hC0, 7'd5,  7'd0,   8'h01, 0, 7'd60};
      vecs[6] = '{8'h90, 7'd64, 7'd1,   8'h03, 1, 7'd64};
      vecs[7] = '{8'h91, 7'd70, 7'd10,  8'h07, 2, 7'd70};
      vecs[8] = '{8'h8F, 7'd99, 7'd0,   8'h07, 2, 7'd70};

      vif.event_valid   = 1'b0;
      vif.event_command = '0;
      vif.event_param1  = '0;
      vif.event_param2  = '0;
      vif.voice_idle    = '1;

      // Reset state and first note-on latency
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("rst_gate", 64'(vif.voice_gate), 64'h0);
      checkOutput("rst_note", 64'(vif.voice_note), 64'h0);
      checkOutput("rst_ack", 64'(vif.event_ack), 64'h0);
      checkOutput("rst_busy", 64'(vif.busy), 64'h0);
      rst = 1'b0;

      applyStimulus(8'h90, 7'd60, 7'd100);
      checkOutput("ack_pulse", 64'(vif.event_ack), 64'h1);
      @(negedge clk);
      checkOutput("ack_width", 64'(vif.event_ack), 64'h0);
      for (int k = 1; k <= NV + 1; k++) begin
         if (k > 1) @(negedge clk);
         checkOutput("busy_hold", 64'(vif.busy), 64'h1);
      end
      checkOutput("gate_early", 64'(vif.voice_gate), 64'h0);
      @(negedge clk);
      checkOutput("gate_on_latency", 64'(vif.voice_gate), 64'h01);
      checkOutput("note0_60", 64'(noteOf(0)), 64'd60);
      checkOutput("busy_done", 64'(vif.busy), 64'h0);

      // Table of allocation / release / ignore vectors
      for (int v = 0; v < 9; v++) begin
         applyStimulus(vecs[v].cmd, vecs[v].p1, vecs[v].p2);
         waitIdle();
         checkOutput($sformatf("tbl%0d_gate", v), 64'(vif.voice_gate), 64'(vecs[v].expGate));
         checkOutput($sformatf("tbl%0d_note", v), 64'(noteOf(vecs[v].voice)), 64'(vecs[v].expNote));
      end

      // Note-off release timing for voice 2 at ack+4
      applyStimulus(8'h80, 7'd70, 7'd0);
      repeat (3) @(negedge clk);
      checkOutput("noff_v2_before", 64'(vif.voice_gate[2]), 64'h1);
      @(negedge clk);
      checkOutput("noff_v2_after", 64'(vif.voice_gate), 64'h03);
      waitIdle();

      // Fill all voices, then steal with exact gap timing
      doReset();
      for (int n = 0; n < NV; n++) begin
         applyStimulus(8'h90, 7'(36 + n), 7'd100);
         waitIdle();
      end
      checkOutput("fill_gate", 64'(vif.voice_gate), 64'hFF);
      checkOutput("fill_note7", 64'(noteOf(7)), 64'd43);
      vif.voice_idle = '0;
      applyStimulus(8'h90, 7'd50, 7'd100);
      repeat (NV + 1) @(negedge clk);
      checkOutput("steal_apply_gate", 64'(vif.voice_gate[0]), 64'h1);
      @(negedge clk);
      checkOutput("steal_gate_low", 64'(vif.voice_gate[0]), 64'h0);
      checkOutput("steal_note", 64'(noteOf(0)), 64'd50);
      low = 0;
      while (!vif.voice_gate[0] && low < 300) begin
         low++;
         @(negedge clk);
      end
      checkOutput("steal_gap", 64'(low), 64'(GAP));
      checkOutput("steal_regate", 64'(vif.voice_gate), 64'hFF);
      checkOutput("steal_busy", 64'(vif.busy), 64'h0);
      applyStimulus(8'h90, 7'd51, 7'd100);
      waitIdle();
      checkOutput("steal2_note1", 64'(noteOf(1)), 64'd51);
      checkOutput("steal2_gate", 64'(vif.voice_gate), 64'hFF);

      // All-notes-off and an ignored program change
      applyStimulus(8'hB0, 7'd123, 7'd0);
      repeat (2) @(negedge clk);
      checkOutput("alloff_gate", 64'(vif.voice_gate), 64'h0);
      checkOutput("alloff_note_kept", 64'(noteOf(0)), 64'd50);
      applyStimulus(8'hC0, 7'd5, 7'd0);
      checkOutput("pc_ack", 64'(vif.event_ack), 64'h1);
      waitIdle();
      checkOutput("pc_gate", 64'(vif.voice_gate), 64'h0);

      // Reset in the middle of a steal
      doReset();
      vif.voice_idle = '1;
      for (int n = 0; n < NV; n++) begin
         applyStimulus(8'h90, 7'(36 + n), 7'd100);
         waitIdle();
      end
      applyStimulus(8'h90, 7'd55, 7'd100);
      repeat (NV + 5) @(negedge clk);
      checkOutput("sw_busy", 64'(vif.busy), 64'h1);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("sw_rst_gate", 64'(vif.voice_gate), 64'h0);
      checkOutput("sw_rst_note", 64'(vif.voice_note), 64'h0);
      checkOutput("sw_rst_busy", 64'(vif.busy), 64'h0);
      rst = 1'b0;
      applyStimulus(8'h90, 7'd77, 7'd100);
      waitIdle();
      checkOutput("sw_after_gate", 64'(vif.voice_gate), 64'h01);
      checkOutput("sw_after_note", 64'(noteOf(0)), 64'd77);

      // Randomized events against the reference model
      doReset();
      modelReset();
      for (int e = 0; e < 250; e++) begin
         r     = $urandom_range(0, 99);
         rp1   = 7'(40 + $urandom_range(0, 11));
         rp2   = 7'($urandom_range(0, 127));
         ridle = NV'($urandom);
         if (r < 50) begin
            rc  = {4'h9, 4'($urandom)};
            rp2 = 7'(1 + $urandom_range(0, 126));
         end else if (r < 70) begin
            rc = {4'h8, 4'($urandom)};
         end else if (r < 80) begin
            rc  = {4'h9, 4'($urandom)};
            rp2 = 7'd0;
         end else if (r < 85) begin
            rc  = {4'hB, 4'($urandom)};
            rp1 = 7'd123;
         end else if (r < 90) begin
            rc = {4'hB, 4'($urandom)};
         end else begin
            rc = {(r < 95) ? 4'hC : 4'hE, 4'($urandom)};
         end
         vif.voice_idle = ridle;
         applyStimulus(rc, rp1, rp2);
         waitIdle();
         modelEvent(rc, rp1, rp2, ridle);
         expGate  = '0;
         expNotes = '0;
         for (int i = 0; i < NV; i++) begin
            expGate[i]        = mGate[i];
            expNotes[7*i +: 7] = mNote[i];
         end
         checkOutput($sformatf("rnd%0d_gate", e), 64'(vif.voice_gate), expGate);
         checkOutput($sformatf("rnd%0d_notes", e), 64'(vif.voice_note), expNotes);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
